ex_mem_pipe_reg: RTL

Parametrised EX/MEM pipeline register for the five-stage datapath. It replaces the plain clocked latch with:
- asynchronous active-low reset;
- a per-entry valid bit and stall (hold) support;
- flush (bubble insertion), so control hazards and load-use stalls are handled at the register;
- 1 to 4 back-to-back register slots for retiming;
- a registered branch-resolution output.

It sits between the ALU/branch-adder outputs and the data-memory / MEM-WB stage.

---
 rtl/ex_mem_pkg.sv | 22 ++
 rtl/ex_mem_pipe_reg_if.sv | 34 +++
 rtl/ex_mem_slot.sv | 85 ++++++++
 rtl/ex_mem_pipe_reg.sv | 106 ++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
package ex_mem_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int STAGES_MIN     = 1;
    localparam int STAGES_MAX     = 4;

    typedef struct packed {
        logic wb_rw;
        logic wb_mtoreg;
        logic m_branch;
        logic m_mem_read;
        logic m_mem_write;
    } ctrl_t;

    // An invalid entry must never carry live control bits downstream.
    function automatic ctrl_t gate_ctrl(ctrl_t c, logic v);
        return v ? c : '0;
    endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM bus: EX-side inputs, registered MEM-side outputs and perf counters.
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 16
);
    logic                  Stall, Flush, InValid;
    logic                  WBrw, WBmtoreg, MBranch, MMemRead, MMemWrite;
    logic [DATA_W-1:0]     AddResult, ALUResult, ReadData2;
    logic                  Zero;
    logic [REG_ADDR_W-1:0] ExtoMemWB;

    logic                  OutValid, OutWBrw, OutWBmtoreg, OutBranch;
    logic                  OutMemRead, OutMemWrite, OutZero, OutPCSrc;
    logic [DATA_W-1:0]     OutAddResult, OutALUResult, OutReadData2;
    logic [REG_ADDR_W-1:0] OutExtoMemWB;
    logic [COUNT_W-1:0]    StallCount, BubbleCount;

    modport master (
        output Stall, Flush, InValid, WBrw, WBmtoreg, MBranch, MMemRead, MMemWrite,
               AddResult, Zero, ALUResult, ReadData2, ExtoMemWB,
        input  OutValid, OutWBrw, OutWBmtoreg, OutBranch, OutMemRead, OutMemWrite,
               OutZero, OutPCSrc, OutAddResult, OutALUResult, OutReadData2,
               OutExtoMemWB, StallCount, BubbleCount
    );

    modport slave (
        input  Stall, Flush, InValid, WBrw, WBmtoreg, MBranch, MMemRead, MMemWrite,
               AddResult, Zero, ALUResult, ReadData2, ExtoMemWB,
        output OutValid, OutWBrw, OutWBmtoreg, OutBranch, OutMemRead, OutMemWrite,
               OutZero, OutPCSrc, OutAddResult, OutALUResult, OutReadData2,
               OutExtoMemWB, StallCount, BubbleCount
    );
endinterface

// File: rtl/ex_mem_slot.sv
// One EX/MEM slot: flush clears valid/control, stall holds, otherwise load.
module ex_mem_slot
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  ctrl_t                 in_ctrl,
    input  logic                  in_zero,
    input  logic [DATA_W-1:0]     in_add,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_rd2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  out_valid,
    output ctrl_t                 out_ctrl,
    output logic                  out_zero,
    output logic [DATA_W-1:0]     out_add,
    output logic [DATA_W-1:0]     out_alu,
    output logic [DATA_W-1:0]     out_rd2,
    output logic [REG_ADDR_W-1:0] out_rd
);

    logic                  valid_q, valid_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  zero_q, zero_d;
    logic [DATA_W-1:0]     add_q, add_d, alu_q, alu_d, rd2_q, rd2_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        zero_d  = zero_q;
        add_d   = add_q;
        alu_d   = alu_q;
        rd2_d   = rd2_q;
        rd_d    = rd_q;
        if (flush) begin
            // Bubble: data fields are left alone, only valid/control die.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!stall) begin
            valid_d = in_valid;
            ctrl_d  = gate_ctrl(in_ctrl, in_valid);
            zero_d  = in_zero;
            add_d   = in_add;
            alu_d   = in_alu;
            rd2_d   = in_rd2;
            rd_d    = in_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            zero_q  <= 1'b0;
            add_q   <= '0;
            alu_q   <= '0;
            rd2_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            zero_q  <= zero_d;
            add_q   <= add_d;
            alu_q   <= alu_d;
            rd2_q   <= rd2_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_zero  = zero_q;
    assign out_add   = add_q;
    assign out_alu   = alu_q;
    assign out_rd2   = rd2_q;
    assign out_rd    = rd_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: STAGES-deep slot chain, branch resolve, counters.
// Optional perf counters are built when EX_MEM_PERF_EN is defined.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int STAGES     = 1,
    parameter int COUNT_W    = 16
) (
    input logic             Clk,
    input logic             Rst_n,
    ex_mem_pipe_reg_if.slave bus
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("ex_mem_pipe_reg: STAGES must be within 1..4");
    end

    // Index 0 is the EX-side input, index k+1 is the output of slot k.
    logic [STAGES:0]                 vld, zero;
    ctrl_t [STAGES:0]                ctl;
    logic [STAGES:0][DATA_W-1:0]     add, alu, rd2;
    logic [STAGES:0][REG_ADDR_W-1:0] rd;

    assign vld[0]  = bus.InValid;
    assign ctl[0]  = '{wb_rw: bus.WBrw, wb_mtoreg: bus.WBmtoreg, m_branch: bus.MBranch,
                       m_mem_read: bus.MMemRead, m_mem_write: bus.MMemWrite};
    assign zero[0] = bus.Zero;
    assign add[0]  = bus.AddResult;
    assign alu[0]  = bus.ALUResult;
    assign rd2[0]  = bus.ReadData2;
    assign rd[0]   = bus.ExtoMemWB;

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        ex_mem_slot #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_slot (
            .clk      (Clk),
            .rst_n    (Rst_n),
            .stall    (bus.Stall),
            .flush    (bus.Flush),
            .in_valid (vld[k]),
            .in_ctrl  (ctl[k]),
            .in_zero  (zero[k]),
            .in_add   (add[k]),
            .in_alu   (alu[k]),
            .in_rd2   (rd2[k]),
            .in_rd    (rd[k]),
            .out_valid(vld[k+1]),
            .out_ctrl (ctl[k+1]),
            .out_zero (zero[k+1]),
            .out_add  (add[k+1]),
            .out_alu  (alu[k+1]),
            .out_rd2  (rd2[k+1]),
            .out_rd   (rd[k+1])
        );
    end

    assign bus.OutValid     = vld[STAGES];
    assign bus.OutWBrw      = ctl[STAGES].wb_rw;
    assign bus.OutWBmtoreg  = ctl[STAGES].wb_mtoreg;
    assign bus.OutBranch    = ctl[STAGES].m_branch;
    assign bus.OutMemRead   = ctl[STAGES].m_mem_read;
    assign bus.OutMemWrite  = ctl[STAGES].m_mem_write;
    assign bus.OutZero      = zero[STAGES];
    assign bus.OutAddResult = add[STAGES];
    assign bus.OutALUResult = alu[STAGES];
    assign bus.OutReadData2 = rd2[STAGES];
    assign bus.OutExtoMemWB = rd[STAGES];
    assign bus.OutPCSrc     = vld[STAGES] & ctl[STAGES].m_branch & zero[STAGES];

`ifdef EX_MEM_PERF_EN
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
    logic               last_loads_bubble;

    // A held slot does not "load", so only flush or a shift of an invalid entry counts.
    assign last_loads_bubble = bus.Flush | (~bus.Stall & ~vld[STAGES-1]);

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.Stall && !bus.Flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (last_loads_bubble && bubble_cnt_q != '1)
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.StallCount  = stall_cnt_q;
    assign bus.BubbleCount = bubble_cnt_q;
`else
    assign bus.StallCount  = '0;
    assign bus.BubbleCount = '0;
`endif

endmodule
